// File: rtl/bch_encoder.sv
// Serial systematic BCH(63,51) encoder, one bit per clock.
// Message bits pass straight through a single-entry output register while an
// LFSR accumulates the remainder; the 12 parity bits are then shifted out
// MSB-first behind the message. Output register drains under valid/ready.
module bch_encoder #(
    parameter int unsigned N   = 63,
    parameter int unsigned K   = 51,
    parameter logic [12:0] GEN = 13'b1_0101_0011_1001
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    input  logic out_ready
);

    localparam int unsigned PW = N - K;
    localparam int unsigned CW = 6;
    localparam logic [PW-1:0]  POLY     = GEN[PW-1:0];
    localparam logic [CW-1:0]  MSG_LAST = CW'(K - 1);
    localparam logic [CW-1:0]  PAR_LAST = CW'(PW - 1);

    typedef enum logic {
        MSG = 1'b0,
        PAR = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  lfsr_q, lfsr_d;
    logic           out_valid_q, out_valid_d;
    logic           out_data_q, out_data_d;
    logic           slot_free;
    logic           fb;

    // Output slot is usable when empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == MSG) && slot_free;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // State, counter, LFSR and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MSG;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state: feed message through the divider, then shift parity out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        fb          = 1'b0;

        if (slot_free) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            MSG: begin
                if (in_valid && in_ready) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    fb          = in_data ^ lfsr_q[PW-1];
                    lfsr_d      = {lfsr_q[PW-2:0], 1'b0} ^ (fb ? POLY : '0);
                    if (cnt_q == MSG_LAST) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
                if (slot_free) begin
                    out_data_d  = lfsr_q[PW-1];
                    out_valid_d = 1'b1;
                    lfsr_d      = {lfsr_q[PW-2:0], 1'b0};
                    if (cnt_q == PAR_LAST) begin
                        cnt_d   = '0;
                        state_d = MSG;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = MSG;
            end
        endcase
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Directed and randomised stimulus for bch_encoder; expected codewords come
// from a polynomial long-division model of m(x)*x^12 mod g(x).
module tb_bch_encoder;

    localparam logic [12:0] GEN = 13'b1_0101_0011_1001;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_ready;

    int checks = 0;
    int errors = 0;

    logic rdy_s, ov_s, od_s, acc;
    logic got[$];
    logic exp_bits[$];
    logic in_bits[$];
    int   nframes;

    bch_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Remainder of a 63-bit polynomial (bit i = coeff x^i) modulo g(x).
    function automatic logic [11:0] rem_of(input logic [62:0] v);
        logic [62:0] r;
        r = v;
        for (int i = 62; i >= 12; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ GEN;
        end
        return r[11:0];
    endfunction

    // Parity field of collected frame f, first-transmitted bit as MSB.
    function automatic logic [11:0] par_of(input int f);
        logic [11:0] p;
        p = 12'hfff;
        if (got.size() >= 63 * f + 63) begin
            for (int j = 0; j < 12; j++) p[11-j] = got[63*f+51+j];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, record handshakes.
    task automatic cyc(input logic iv, input logic id, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        rdy_s = in_ready;
        ov_s  = out_valid;
        od_s  = out_data;
        if (ov_s === 1'b1 && ordy) got.push_back(od_s);
        acc = iv && (rdy_s === 1'b1);
        @(posedge clk);
    endtask

    task automatic clear_frames();
        got.delete();
        exp_bits.delete();
        in_bits.delete();
        nframes = 0;
    endtask

    task automatic add_frame(input logic [50:0] m);
        logic [62:0] cw;
        cw = {m, rem_of({m, 12'b0})};
        for (int i = 50; i >= 0; i--) in_bits.push_back(m[i]);
        for (int i = 62; i >= 0; i--) exp_bits.push_back(cw[i]);
        nframes++;
    endtask

    // Stream all queued frames, optionally stalling the sink, then compare.
    task automatic run(input int unsigned pv, input int unsigned pr,
                       input int stall_at, input int stall_len, input bit stream);
        int bi;
        int c;
        int budget;
        int stl;
        int f_end;
        logic iv, id, ordy;
        logic [62:0] g, e;
        bi     = 0;
        c      = 0;
        stl    = stall_len;
        f_end  = 63 * nframes;
        budget = 40 * exp_bits.size() + 100;
        got.delete();
        while (got.size() < exp_bits.size() && c < budget) begin
            if (stl > 0 && got.size() == stall_at) begin
                for (int s = 0; s < stl; s++) begin
                    cyc(1'b0, 1'b0, 1'b0);
                    chk("stall_valid", 64'(ov_s), 64'd1);
                    chk("stall_data", 64'(od_s), 64'(exp_bits[stall_at]));
                    chk("stall_ready", 64'(rdy_s), 64'd0);
                    c++;
                end
                stl = 0;
            end
            iv   = (bi < in_bits.size()) && ($urandom_range(99) < pv);
            id   = iv ? in_bits[bi] : 1'b0;
            ordy = $urandom_range(99) < pr;
            cyc(iv, id, ordy);
            if (stream) begin
                chk("stream_valid", 64'(ov_s), 64'(c >= 1 && c <= f_end));
                chk("stream_ready", 64'(rdy_s), 64'((c >= f_end) || ((c % 63) < 51)));
            end
            if (acc) bi++;
            c++;
        end
        chk("out_count", 64'(got.size()), 64'(exp_bits.size()));
        for (int f = 0; f < nframes; f++) begin
            if (got.size() >= 63 * f + 63) begin
                for (int j = 0; j < 63; j++) begin
                    g[62-j] = got[63*f+j];
                    e[62-j] = exp_bits[63*f+j];
                end
                chk("codeword", 64'(g), 64'(e));
                chk("divisible", 64'(rem_of(g)), 64'd0);
            end
        end
    endtask

    initial begin
        logic [63:0] r;
        int n_acc;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Zero frame, last-bit frame, zero frame back to back at full rate.
        clear_frames();
        add_frame(51'd0);
        add_frame(51'd1);
        add_frame(51'd0);
        run(100, 100, 0, 0, 1'b1);
        chk("zero_parity", 64'(par_of(0)), 64'h000);
        chk("lastbit_parity", 64'(par_of(1)), 64'h539);
        chk("selfclear_parity", 64'(par_of(2)), 64'h000);

        // Sink stalls for 20 cycles in the middle of the parity field.
        clear_frames();
        add_frame(51'h2_D3C5_9A7E_1B3F);
        run(100, 100, 56, 20, 1'b0);

        // 200 random frames with random source and sink gaps.
        clear_frames();
        for (int i = 0; i < 200; i++) begin
            r = {$urandom(), $urandom()};
            add_frame(r[50:0]);
        end
        run(50, 50, 0, 0, 1'b0);

        // Abort a frame with reset after 30 message bits.
        clear_frames();
        n_acc = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (acc) n_acc++;
        end
        chk("pre_reset_accepts", 64'(n_acc), 64'd30);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_data", 64'(out_data), 64'd0);
        chk("async_reset_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        add_frame(51'd1);
        run(100, 100, 0, 0, 1'b0);
        chk("post_reset_parity", 64'(par_of(0)), 64'h539);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_encoder.md
# bch_encoder

Serial systematic BCH(63,51) encoder, t = 2, one bit per clock. It sits directly upstream of the channel and the `bch_decoder` stage. It accepts 51 message bits MSB-first over a valid/ready stream and forwards them unchanged. It then appends 12 parity bits computed with an LFSR, producing 63-bit codewords in the same bit order `bch_decoder` consumes.

## Interface
Parameters:
- `N`, 63: codeword length in bits.
- `K`, 51: message length in bits; `N-K` = 12 parity bits.
- `GEN`, 13'b1_0101_0011_1001: generator g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1 (octal 12471), bit i = coeff x^i. Only the defaults are supported and verified.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset (block in reset while 0).
- `in_valid`  input  1  `in_data` holds a message bit.
- `in_data`  input  1  message bit; the first bit of a frame is coeff x^62.
- `in_ready`  output  1  encoder accepts a message bit this cycle.
- `out_valid`  output  1  `out_data` holds a codeword bit.
- `out_data`  output  1  codeword bit, registered.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.

## Operation
- State machine: `MSG` (reset state) and `PAR`.
  - Bit counter `cnt` is 6 bits wide.
  - Parity register `lfsr[11:0]` is cleared on reset.
- `slot_free` = !out_valid || out_ready. This is the single-entry output register being empty or draining this cycle.
- `in_ready` = (state == MSG) && slot_free. It is combinational and has no dependence on `in_valid`.
- MSG, on an accepted bit (in_valid && in_ready):
  - `out_data` <= in_data and `out_valid` <= 1.
  - fb = in_data ^ lfsr[11]; lfsr <= {lfsr[10:0],1'b0} ^ (fb ? GEN[11:0] : 0).
  - `cnt` increments. On the 51st bit (cnt == K-1), `cnt` <= 0 and state <= PAR.
- PAR, when slot_free:
  - `out_data` <= lfsr[11], `out_valid` <= 1, lfsr <= {lfsr[10:0],1'b0}. Parity goes out MSB-first, coeff x^11 first.
  - `cnt` increments. On the 12th parity bit (cnt == N-K-1), `cnt` <= 0 and state <= MSG.
  - After the 12 shifts `lfsr` is all zero, ready for the next frame with no extra clear.
- If slot_free and no new bit is loaded this cycle, `out_valid` <= 0.
- `out_data` is held stable while out_valid && !out_ready.
- Each output bit is the 63-bit codeword c(x) = m(x)·x^12 + (m(x)·x^12 mod g(x)), in order x^62 .. x^0.
- Frames are implicit: the 51-bit message count is fixed and no framing signal exists. Upstream must deliver whole frames.

## Timing
- Reset (rst = 0, asynchronous): `out_valid` = 0, `out_data` = 0, state = MSG, `cnt` = 0, `lfsr` = 0.
  - `in_ready` = 1 immediately, because the output slot is empty.
- Deassertion of reset is synchronous to `clk` at the first rising edge. Upstream must not present data before that edge.
- Latency: a bit accepted at edge n appears on `out_data` with `out_valid` = 1 after edge n, i.e. 1 cycle.
- The first parity bit is presented at the edge after the 51st message bit is taken, provided `out_ready` = 1.
- Throughput with `out_ready` held at 1 and `in_valid` held at 1:
  - 63 output bits per 63 cycles, continuous `out_valid`.
  - `in_ready` is high 51 cycles and low 12 cycles per frame.
- Back-pressure: while out_valid && !out_ready, `in_ready` = 0 and no state, counter or LFSR update occurs, including in PAR.
- `in_valid` gaps in MSG stall the frame. Partial LFSR state and `cnt` are retained indefinitely.
- Reset mid-frame aborts the frame: the partial codeword is dropped and the next accepted bit is message bit x^62.

## Test plan
- All-zero message, out_ready = 1: 63 output bits all 0, parity 12'h000. Next frame starts without a gap.
- Message with only the last bit (51st) = 1:
  - Outputs are 50 zeros, then 1, then parity 010100111001 (12'h539), MSB first.
  - The following all-zero frame yields parity 12'h000, proving the LFSR self-clears.
- 200 random frames with in_valid and out_ready each randomised at 50%:
  - Collected codewords match the bench model m·x^12 + rem.
  - Each collected word is divisible by g(x).
  - Each is decoded error-free by `bch_decoder` when chained.
  - No bit is lost or duplicated under stalls.
- out_ready = 0 for 20 cycles during PAR, mid-parity: `out_data` and `out_valid` held stable and `in_ready` = 0. Remaining parity bits are correct after release.
- rst pulled low at message bit 30:
  - `out_valid` drops to 0 asynchronously (same cycle).
  - After release, the single-1 last-bit message from the second scenario produces parity 12'h539.
- Continuous streaming, in_valid = out_ready = 1 for 3 frames:
  - `out_valid` is high every cycle after the first.
  - `in_ready` is low exactly during output cycles 52–63 of each frame.
